axi_wdata_issue: RTL and testbench

- Drain side of the iDMA write path: pops 288-bit words (256 data + 32 strobe) from a first-word-fall-through data FIFO on the destination clock.
- Drives them as AXI write-data (W) beats, with WLAST framing from a per-burst length command issued by the AW-side logic.
- Registered W output. One beat per cycle within a burst; one bubble cycle between bursts.

---
 rtl/axi_wdata_issue_pkg.sv | 19 +
 rtl/axi_wdata_issue_if.sv | 39 +++
 rtl/axi_wdata_issue.sv | 109 ++++++++++
 tb/tb_axi_wdata_issue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wdata_issue_pkg.sv
// Shared definitions for the iDMA write-data issue path: widths, FSM encoding
// and the layout of data/strobe fields inside a FIFO word.
package axi_wdata_issue_pkg;

    localparam int DATA_W     = 256;
    localparam int STRB_W     = DATA_W / 8;
    localparam int LEN_W      = 8;
    localparam int FIFO_WIDTH = 288;

    // Field placement inside a FIFO word, also used by the AR/R-side packer.
    localparam int WDATA_LSB  = 0;
    localparam int WSTRB_LSB  = DATA_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/axi_wdata_issue_if.sv
// Bundles the burst command, data FIFO drain and AXI W channel of the
// write-data issue block; master is the issuing side, slave the environment.
interface axi_wdata_issue_if #(
    parameter int DATA_W     = axi_wdata_issue_pkg::DATA_W,
    parameter int STRB_W     = axi_wdata_issue_pkg::STRB_W,
    parameter int FIFO_WIDTH = axi_wdata_issue_pkg::FIFO_WIDTH,
    parameter int LEN_W      = axi_wdata_issue_pkg::LEN_W
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_W-1:0]      cmd_len;

    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data;
    logic                  fifo_pop;

    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [STRB_W-1:0]     m_axi_wstrb;
    logic                  m_axi_wlast;

    logic                  burst_done;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_len, fifo_empty, fifo_data, m_axi_wready,
        output cmd_ready, fifo_pop, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        output m_axi_wlast, burst_done, busy
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_empty, fifo_data, m_axi_wready,
        input  cmd_ready, fifo_pop, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        input  m_axi_wlast, burst_done, busy
    );

endinterface

// File: rtl/axi_wdata_issue.sv
// Drains the FWFT data FIFO into registered AXI W beats, framing each burst
// with WLAST from the AW-side length command.
module axi_wdata_issue #(
    parameter int DATA_W     = axi_wdata_issue_pkg::DATA_W,
    parameter int STRB_W     = axi_wdata_issue_pkg::STRB_W,
    parameter int FIFO_WIDTH = axi_wdata_issue_pkg::FIFO_WIDTH,
    parameter int LEN_W      = axi_wdata_issue_pkg::LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    axi_wdata_issue_if.master   bus
);
    import axi_wdata_issue_pkg::*;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                wvalid_q, wvalid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                wlast_q, wlast_d;
    logic                done_q, done_d;

    logic                clear;
    logic                out_free;
    logic                last_beat;
    logic                load;

    assign clear     = rst | init;
    assign out_free  = !wvalid_q | bus.m_axi_wready;
    assign last_beat = (beat_cnt_q == len_q);

    // Clear masks the pop so a reset cycle never consumes a FIFO word.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        load          = 1'b0;
        bus.cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    len_d      = bus.cmd_len;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (out_free && !bus.fifo_empty && !clear) begin
                    load       = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wvalid_d = wvalid_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        wlast_d  = wlast_q;
        if (load) begin
            wvalid_d = 1'b1;
            wdata_d  = bus.fifo_data[DATA_W-1:0];
            wstrb_d  = bus.fifo_data[DATA_W+STRB_W-1:DATA_W];
            wlast_d  = last_beat;
        end else if (wvalid_q && bus.m_axi_wready) begin
            wvalid_d = 1'b0;
        end
        done_d = wvalid_q & bus.m_axi_wready & wlast_q;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wlast_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wlast_q    <= wlast_d;
            done_q     <= done_d;
        end
    end

    assign bus.fifo_pop     = load;
    assign bus.m_axi_wvalid = wvalid_q;
    assign bus.m_axi_wdata  = wdata_q;
    assign bus.m_axi_wstrb  = wstrb_q;
    assign bus.m_axi_wlast  = wlast_q;
    assign bus.burst_done   = done_q;
    assign bus.busy         = (state_q != IDLE) | wvalid_q;

endmodule

// File: tb/tb_axi_wdata_issue.sv
// Bench for axi_wdata_issue: a queue-based FIFO and a beat-stream model
// (words in push order, WLAST from accepted command lengths) check every beat.
module tb_axi_wdata_issue;
    import axi_wdata_issue_pkg::*;

    localparam int DW = DATA_W;
    localparam int SW = STRB_W;
    localparam int FW = FIFO_WIDTH;
    localparam int LW = LEN_W;
    localparam int CW = 320;

    logic clk = 1'b0;
    logic rst;
    logic init;

    axi_wdata_issue_if #(.DATA_W(DW), .STRB_W(SW), .FIFO_WIDTH(FW), .LEN_W(LW)) bus ();

    axi_wdata_issue #(.DATA_W(DW), .STRB_W(SW), .FIFO_WIDTH(FW), .LEN_W(LW)) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared    = 0;
    int mismatched  = 0;
    int cycleNo     = 0;
    int hsCount     = 0;
    int popCount    = 0;
    int doneCount   = 0;
    int lastHsCycle = 0;
    int feedPct     = 100;
    int wrMode      = 0;

    logic [FW-1:0] fifoQ[$];
    logic [FW-1:0] pendingWords[$];
    logic [FW-1:0] pushedWords[$];
    bit            lastFlags[$];
    logic [LW-1:0] pendingCmds[$];
    int            acceptCycles[$];

    bit            expDone        = 1'b0;
    bit            prevStall      = 1'b0;
    bit            expectNotReady = 1'b0;
    logic [CW-1:0] heldBeat       = '0;

    task automatic checkOutput(input string tag, input logic [CW-1:0] observed,
                               input logic [CW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [FW-1:0] randWord();
        logic [FW-1:0] w;
        w = '0;
        for (int i = 0; i < FW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [FW-1:0] makeWord(input logic [DW-1:0] data, input logic [SW-1:0] strb);
        logic [FW-1:0] w;
        w = '0;
        w[DW-1:0]     = data;
        w[DW+SW-1:DW] = strb;
        return w;
    endfunction

    task automatic driveInputs();
        bus.fifo_empty = (fifoQ.size() == 0);
        bus.fifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : '0;
        bus.cmd_valid  = (pendingCmds.size() != 0);
        bus.cmd_len    = (pendingCmds.size() != 0) ? pendingCmds[0] : '0;
    endtask

    // One clock: check at the falling edge, then update the model and drive after the rising edge.
    task automatic applyStimulus();
        bit            hs, pop, accepted, inClear, expLast, ok;
        logic [LW-1:0] len;
        logic [FW-1:0] w;
        @(negedge clk);
        cycleNo++;
        inClear  = rst | init;
        hs       = bus.m_axi_wvalid & bus.m_axi_wready;
        pop      = bus.fifo_pop;
        accepted = bus.cmd_valid & bus.cmd_ready;
        expLast  = 1'b0;
        if (inClear) begin
            expDone        = 1'b0;
            prevStall      = 1'b0;
            expectNotReady = 1'b0;
            pop            = 1'b0;
            accepted       = 1'b0;
        end else begin
            checkOutput("burst_done", CW'(bus.burst_done), CW'(expDone));
            if (bus.burst_done) doneCount++;
            if (expectNotReady) checkOutput("cmd_ready_after_accept", CW'(bus.cmd_ready), '0);
            if (bus.fifo_empty) checkOutput("pop_when_empty", CW'(pop), '0);
            if (prevStall) begin
                checkOutput("stall_wvalid", CW'(bus.m_axi_wvalid), CW'(1));
                checkOutput("stall_beat",
                            CW'({bus.m_axi_wlast, bus.m_axi_wstrb, bus.m_axi_wdata}), heldBeat);
            end
            if (hs) begin
                ok = (hsCount < lastFlags.size()) && (hsCount < pushedWords.size());
                checkOutput("beat_expected", CW'(ok), CW'(1));
                if (ok) begin
                    checkOutput("wdata", CW'(bus.m_axi_wdata), CW'(pushedWords[hsCount][DW-1:0]));
                    checkOutput("wstrb", CW'(bus.m_axi_wstrb), CW'(pushedWords[hsCount][DW+SW-1:DW]));
                    checkOutput("wlast", CW'(bus.m_axi_wlast), CW'(lastFlags[hsCount]));
                    expLast = lastFlags[hsCount];
                end
                hsCount++;
                lastHsCycle = cycleNo;
            end
            expDone        = expLast;
            prevStall      = bus.m_axi_wvalid & !bus.m_axi_wready;
            heldBeat       = CW'({bus.m_axi_wlast, bus.m_axi_wstrb, bus.m_axi_wdata});
            expectNotReady = accepted;
            if (accepted) begin
                len = bus.cmd_len;
                for (int i = 0; i <= int'(len); i++) lastFlags.push_back(i == int'(len));
                acceptCycles.push_back(cycleNo);
            end
        end
        @(posedge clk);
        #1;
        if (pop) begin
            popCount++;
            if (fifoQ.size() != 0) void'(fifoQ.pop_front());
        end
        if (accepted && pendingCmds.size() != 0) void'(pendingCmds.pop_front());
        if (pendingWords.size() != 0 && $urandom_range(0, 99) < feedPct) begin
            w = pendingWords.pop_front();
            fifoQ.push_back(w);
            pushedWords.push_back(w);
        end
        case (wrMode)
            0:       bus.m_axi_wready = 1'b1;
            1:       bus.m_axi_wready = ((cycleNo % 4) == 0) || ((cycleNo % 4) == 3);
            default: bus.m_axi_wready = 1'($urandom_range(0, 1));
        endcase
        driveInputs();
    endtask

    task automatic drainWait(input int budget);
        int n;
        n = 0;
        while (n < budget && !(hsCount == lastFlags.size() && pendingCmds.size() == 0 &&
                               pendingWords.size() == 0 && !bus.busy)) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_beats", CW'(hsCount), CW'(lastFlags.size()));
        applyStimulus();
    endtask

    // Clears DUT and the bench FIFO; beats not yet handshaken are dropped from the model.
    task automatic doReset(input bit useInit);
        pendingCmds.delete();
        pendingWords.delete();
        fifoQ.delete();
        bus.m_axi_wready = 1'b0;
        if (useInit) init = 1'b1;
        else         rst  = 1'b1;
        driveInputs();
        applyStimulus();
        rst  = 1'b0;
        init = 1'b0;
        while (pushedWords.size() > hsCount) void'(pushedWords.pop_back());
        while (lastFlags.size() > hsCount) void'(lastFlags.pop_back());
        checkOutput("rst_wvalid",     CW'(bus.m_axi_wvalid), '0);
        checkOutput("rst_wdata",      CW'(bus.m_axi_wdata), '0);
        checkOutput("rst_wstrb",      CW'(bus.m_axi_wstrb), '0);
        checkOutput("rst_wlast",      CW'(bus.m_axi_wlast), '0);
        checkOutput("rst_burst_done", CW'(bus.burst_done), '0);
        checkOutput("rst_cmd_ready",  CW'(bus.cmd_ready), CW'(1));
        checkOutput("rst_busy",       CW'(bus.busy), '0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0, d0, h0, nb;
        logic [LW-1:0] rl;
        rst  = 1'b1;
        init = 1'b0;
        bus.m_axi_wready = 1'b0;
        driveInputs();
        doReset(1'b0);

        $display("[TB] burst len 3, preloaded FIFO");
        wrMode = 0;
        feedPct = 100;
        for (int i = 1; i <= 4; i++) pendingWords.push_back(makeWord(DW'(i), '1));
        repeat (5) applyStimulus();
        p0 = popCount;
        d0 = doneCount;
        pendingCmds.push_back(LW'(3));
        driveInputs();
        drainWait(50);
        checkOutput("t1_latency", CW'(lastHsCycle - acceptCycles[$]), CW'(5));
        checkOutput("t1_pops", CW'(popCount - p0), CW'(4));
        checkOutput("t1_done", CW'(doneCount - d0), CW'(1));

        $display("[TB] single-beat burst");
        pendingWords.push_back(randWord());
        repeat (3) applyStimulus();
        pendingCmds.push_back(LW'(0));
        driveInputs();
        drainWait(50);
        checkOutput("t2_latency", CW'(lastHsCycle - acceptCycles[$]), CW'(2));
        checkOutput("t2_cmd_ready", CW'(bus.cmd_ready), CW'(1));

        $display("[TB] len 7 with wready stalls");
        wrMode = 1;
        for (int i = 0; i < 8; i++) pendingWords.push_back(randWord());
        repeat (9) applyStimulus();
        pendingCmds.push_back(LW'(7));
        driveInputs();
        drainWait(100);

        $display("[TB] FIFO runs dry mid-burst");
        wrMode = 0;
        for (int i = 0; i < 2; i++) pendingWords.push_back(randWord());
        repeat (3) applyStimulus();
        h0 = hsCount;
        pendingCmds.push_back(LW'(3));
        driveInputs();
        repeat (8) applyStimulus();
        checkOutput("gap_beats", CW'(hsCount - h0), CW'(2));
        checkOutput("gap_wvalid", CW'(bus.m_axi_wvalid), '0);
        for (int i = 0; i < 2; i++) pendingWords.push_back(randWord());
        drainWait(50);

        $display("[TB] back-to-back commands");
        for (int i = 0; i < 5; i++) pendingWords.push_back(randWord());
        repeat (6) applyStimulus();
        d0 = doneCount;
        pendingCmds.push_back(LW'(1));
        pendingCmds.push_back(LW'(2));
        driveInputs();
        drainWait(50);
        checkOutput("b2b_accept_gap", CW'(acceptCycles[$] - acceptCycles[$-1]), CW'(3));
        checkOutput("b2b_done", CW'(doneCount - d0), CW'(2));

        $display("[TB] reset during len 15 burst");
        for (int i = 0; i < 16; i++) pendingWords.push_back(randWord());
        repeat (17) applyStimulus();
        pendingCmds.push_back(LW'(15));
        driveInputs();
        repeat (6) applyStimulus();
        checkOutput("pre_reset_wvalid", CW'(bus.m_axi_wvalid), CW'(1));
        doReset(1'b0);
        for (int i = 0; i < 2; i++) pendingWords.push_back(randWord());
        repeat (3) applyStimulus();
        pendingCmds.push_back(LW'(1));
        driveInputs();
        drainWait(50);

        $display("[TB] maximum burst length");
        h0 = hsCount;
        for (int i = 0; i < 256; i++) pendingWords.push_back(randWord());
        pendingCmds.push_back(LW'(255));
        driveInputs();
        drainWait(1000);
        checkOutput("max_len_beats", CW'(hsCount - h0), CW'(256));

        $display("[TB] randomized bursts");
        wrMode = 2;
        for (int batch = 0; batch < 6; batch++) begin
            feedPct = $urandom_range(30, 100);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                rl = LW'($urandom_range(0, 15));
                pendingCmds.push_back(rl);
                for (int i = 0; i <= int'(rl); i++) pendingWords.push_back(randWord());
            end
            driveInputs();
            drainWait(2000);
        end

        $display("[TB] soft init while idle");
        wrMode = 0;
        feedPct = 100;
        doReset(1'b1);
        pendingWords.push_back(randWord());
        repeat (2) applyStimulus();
        pendingCmds.push_back(LW'(0));
        driveInputs();
        drainWait(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
